// File: rtl/critical_request_queue.sv
// Per-way request buffer: two class FIFOs (critical / normal) feeding one registered
// output slot, with critical-first selection limited by an anti-starvation burst counter.
module critical_request_queue #(
    parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
    parameter int CRITICAL_DEPTH               = 4,
    parameter int NORMAL_DEPTH                 = 8,
    parameter int MAX_CRITICAL_BURST           = 4
) (
    input  logic                                    clk_in,
    input  logic                                    reset_in,
    input  logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_in,
    input  logic                                    request_valid_in,
    input  logic                                    request_critical_in,
    output logic                                    request_ready_out,
    output logic [$clog2(CRITICAL_DEPTH):0]         critical_count_out,
    output logic [$clog2(NORMAL_DEPTH):0]           normal_count_out,
    output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_out,
    output logic                                    request_valid_out,
    output logic                                    request_critical_out,
    input  logic                                    issue_ack_in
);

    localparam int W  = SINGLE_REQUEST_WIDTH_IN_BITS;
    localparam int CP = $clog2(CRITICAL_DEPTH);
    localparam int NP = $clog2(NORMAL_DEPTH);
    localparam int BW = $clog2(MAX_CRITICAL_BURST + 1);

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_HOLD
    } slot_state_t;

    slot_state_t slot_state, slot_state_next;

    logic [W-1:0]  crit_mem [CRITICAL_DEPTH];
    logic [W-1:0]  norm_mem [NORMAL_DEPTH];
    logic [CP-1:0] crit_wr_ptr, crit_rd_ptr;
    logic [NP-1:0] norm_wr_ptr, norm_rd_ptr;
    logic [CP:0]   crit_count;
    logic [NP:0]   norm_count;
    logic [BW-1:0] burst_cnt;

    logic crit_full, crit_empty, norm_full, norm_empty;
    logic crit_push, norm_push, crit_pop, norm_pop;
    logic slot_load, sel_crit;

    // Full/empty come from registered counts, so a pop cannot make room for a same-cycle write.
    assign crit_full  = (crit_count == (CP+1)'(CRITICAL_DEPTH));
    assign norm_full  = (norm_count == (NP+1)'(NORMAL_DEPTH));
    assign crit_empty = (crit_count == '0);
    assign norm_empty = (norm_count == '0);

    assign request_ready_out = ~(request_critical_in ? crit_full : norm_full);
    assign crit_push = request_valid_in & request_ready_out &  request_critical_in;
    assign norm_push = request_valid_in & request_ready_out & ~request_critical_in;

    assign sel_crit = ~crit_empty & ((burst_cnt < BW'(MAX_CRITICAL_BURST)) | norm_empty);
    assign crit_pop = slot_load &  sel_crit;
    assign norm_pop = slot_load & ~sel_crit;

    assign critical_count_out = crit_count;
    assign normal_count_out   = norm_count;
    assign request_valid_out  = (slot_state == SLOT_HOLD);

    always_comb begin
        slot_state_next = slot_state;
        slot_load       = 1'b0;
        case (slot_state)
            SLOT_EMPTY: begin
                if (!crit_empty || !norm_empty) begin
                    slot_load       = 1'b1;
                    slot_state_next = SLOT_HOLD;
                end
            end
            SLOT_HOLD: begin
                if (issue_ack_in) begin
                    if (!crit_empty || !norm_empty) begin
                        slot_load = 1'b1;
                    end else begin
                        slot_state_next = SLOT_EMPTY;
                    end
                end
            end
            default: slot_state_next = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (crit_push) crit_mem[crit_wr_ptr] <= request_in;
        if (norm_push) norm_mem[norm_wr_ptr] <= request_in;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            crit_wr_ptr <= '0;
            crit_rd_ptr <= '0;
            crit_count  <= '0;
            norm_wr_ptr <= '0;
            norm_rd_ptr <= '0;
            norm_count  <= '0;
        end else begin
            if (crit_push) crit_wr_ptr <= crit_wr_ptr + 1'b1;
            if (crit_pop)  crit_rd_ptr <= crit_rd_ptr + 1'b1;
            if (norm_push) norm_wr_ptr <= norm_wr_ptr + 1'b1;
            if (norm_pop)  norm_rd_ptr <= norm_rd_ptr + 1'b1;
            case ({crit_push, crit_pop})
                2'b10:   crit_count <= crit_count + 1'b1;
                2'b01:   crit_count <= crit_count - 1'b1;
                default: crit_count <= crit_count;
            endcase
            case ({norm_push, norm_pop})
                2'b10:   norm_count <= norm_count + 1'b1;
                2'b01:   norm_count <= norm_count - 1'b1;
                default: norm_count <= norm_count;
            endcase
        end
    end

    // Burst counter only grows while normal traffic is actually being held back.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            slot_state           <= SLOT_EMPTY;
            request_out          <= '0;
            request_critical_out <= 1'b0;
            burst_cnt            <= '0;
        end else begin
            slot_state <= slot_state_next;
            if (slot_load) begin
                request_out          <= sel_crit ? crit_mem[crit_rd_ptr] : norm_mem[norm_rd_ptr];
                request_critical_out <= sel_crit;
                burst_cnt            <= (sel_crit && !norm_empty) ? burst_cnt + 1'b1 : '0;
            end
        end
    end

endmodule

// File: tb/tb_critical_request_queue.sv
// Self-checking bench for critical_request_queue: directed scenarios plus random traffic,
// compared against a queue-based reference model of the two classes and the output slot.
module tb_critical_request_queue;

    localparam int W    = 64;
    localparam int CD   = 4;
    localparam int ND   = 8;
    localparam int MAXB = 4;
    localparam int CCW  = $clog2(CD) + 1;
    localparam int NCW  = $clog2(ND) + 1;

    logic           clk_in = 1'b0;
    logic           reset_in;
    logic [W-1:0]   request_in;
    logic           request_valid_in;
    logic           request_critical_in;
    logic           request_ready_out;
    logic [CCW-1:0] critical_count_out;
    logic [NCW-1:0] normal_count_out;
    logic [W-1:0]   request_out;
    logic           request_valid_out;
    logic           request_critical_out;
    logic           issue_ack_in;

    always #5 clk_in = ~clk_in;

    critical_request_queue #(
        .SINGLE_REQUEST_WIDTH_IN_BITS(W),
        .CRITICAL_DEPTH(CD),
        .NORMAL_DEPTH(ND),
        .MAX_CRITICAL_BURST(MAXB)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .request_in(request_in),
        .request_valid_in(request_valid_in),
        .request_critical_in(request_critical_in),
        .request_ready_out(request_ready_out),
        .critical_count_out(critical_count_out),
        .normal_count_out(normal_count_out),
        .request_out(request_out),
        .request_valid_out(request_valid_out),
        .request_critical_out(request_critical_out),
        .issue_ack_in(issue_ack_in)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: class queues, slot contents, burst counter.
    logic [W-1:0] cq[$];
    logic [W-1:0] nq[$];
    bit           m_valid;
    logic [W-1:0] m_data;
    bit           m_crit;
    int           m_burst;
    logic         rdy_obs;
    logic         rdy_exp;

    task automatic model_reset();
        cq.delete();
        nq.delete();
        m_valid = 0;
        m_data  = '0;
        m_crit  = 0;
        m_burst = 0;
    endtask

    task automatic model_step(input bit v, input bit c, input logic [W-1:0] d, input bit a);
        int  cs, ns;
        bit  acc, ld, sc;
        cs  = cq.size();
        ns  = nq.size();
        acc = v && (c ? (cs < CD) : (ns < ND));
        ld  = (!m_valid || a) && (cs > 0 || ns > 0);
        if (ld) begin
            sc = (cs > 0) && (m_burst < MAXB || ns == 0);
            if (sc) begin
                m_data  = cq.pop_front();
                m_crit  = 1;
                m_burst = (ns == 0) ? 0 : m_burst + 1;
            end else begin
                m_data  = nq.pop_front();
                m_crit  = 0;
                m_burst = 0;
            end
            m_valid = 1;
        end else if (m_valid && a) begin
            m_valid = 0;
        end
        if (acc) begin
            if (c) cq.push_back(d);
            else   nq.push_back(d);
        end
    endtask

    // Drive one cycle of inputs, capture ready, advance DUT and model, return at the falling edge.
    task automatic cycle(input bit v, input bit c, input logic [W-1:0] d, input bit a);
        request_valid_in    = v;
        request_critical_in = c;
        request_in          = d;
        issue_ack_in        = a;
        #1;
        rdy_obs = request_ready_out;
        rdy_exp = c ? (cq.size() < CD) : (nq.size() < ND);
        @(posedge clk_in);
        model_step(v, c, d, a);
        @(negedge clk_in);
    endtask

    task automatic apply_reset();
        reset_in            = 1'b0;
        request_valid_in    = 1'b0;
        request_critical_in = 1'b0;
        request_in          = '0;
        issue_ack_in        = 1'b0;
        repeat (2) @(negedge clk_in);
        reset_in = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_in            = 1'b0;
        request_valid_in    = 1'b0;
        request_critical_in = 1'b0;
        request_in          = '0;
        issue_ack_in        = 1'b0;
        repeat (2) @(negedge clk_in);
        reset_in = 1'b1;
        model_reset();
        #1;
        checks++; if (request_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", request_valid_out); end
        checks++; if (request_out !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", request_out); end
        checks++; if (request_critical_out !== 1'b0) begin errors++; $display("FAIL reset_crit: got %0b expected 0", request_critical_out); end
        checks++; if (critical_count_out !== '0) begin errors++; $display("FAIL reset_ccount: got %0d expected 0", critical_count_out); end
        checks++; if (normal_count_out !== '0) begin errors++; $display("FAIL reset_ncount: got %0d expected 0", normal_count_out); end
        checks++; if (request_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready_normal: got %0b expected 1", request_ready_out); end
        request_critical_in = 1'b1;
        #1;
        checks++; if (request_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready_crit: got %0b expected 1", request_ready_out); end
        request_critical_in = 1'b0;
    endtask

    task automatic test_normal_order();
        logic [W-1:0] vals[3];
        logic [W-1:0] seq[$];
        int first_valid;
        int hold;
        bit a, prevalid;
        logic [W-1:0] d;
        vals = '{64'hA, 64'hB, 64'hC};
        first_valid = -1;
        hold = 0;
        for (int k = 0; k < 20; k++) begin
            d = (k < 3) ? vals[k] : '0;
            a = m_valid && (hold == 1);
            prevalid = m_valid;
            if (a) seq.push_back(request_out);
            cycle(k < 3, 1'b0, d, a);
            if (a || !prevalid) hold = 0;
            else hold++;
            checks++; if (request_valid_out !== m_valid) begin errors++; $display("FAIL order_valid k=%0d: got %0b expected %0b", k, request_valid_out, m_valid); end
            if (m_valid) begin
                checks++; if (request_critical_out !== 1'b0) begin errors++; $display("FAIL order_crit k=%0d: got %0b expected 0", k, request_critical_out); end
            end
            if (request_valid_out && first_valid < 0) first_valid = k + 1;
        end
        checks++; if (first_valid != 2) begin errors++; $display("FAIL order_latency: got %0d expected 2", first_valid); end
        checks++; if (seq.size() != 3) begin errors++; $display("FAIL order_len: got %0d expected 3", seq.size()); end
        for (int i = 0; i < seq.size() && i < 3; i++) begin
            checks++; if (seq[i] !== vals[i]) begin errors++; $display("FAIL order_item%0d: got %0h expected %0h", i, seq[i], vals[i]); end
        end
    endtask

    task automatic test_priority();
        logic [W-1:0] pay[8];
        bit           cls[8];
        logic [W-1:0] exp_order[8];
        bit           exp_cls[8];
        logic [W-1:0] order[$];
        bit           ocls[$];
        int wi;
        bit v, c, a, acc;
        logic [W-1:0] d;
        pay       = '{64'h100, 64'h101, 64'h200, 64'h201, 64'h202, 64'h203, 64'h204, 64'h205};
        cls       = '{0, 0, 1, 1, 1, 1, 1, 1};
        exp_order = '{64'h100, 64'h200, 64'h201, 64'h202, 64'h203, 64'h101, 64'h204, 64'h205};
        exp_cls   = '{0, 1, 1, 1, 1, 0, 1, 1};
        wi = 0;
        for (int k = 0; k < 80 && order.size() < 8; k++) begin
            v = (wi < 8);
            c = 0;
            d = '0;
            if (v) begin
                c = cls[wi];
                d = pay[wi];
            end
            acc = v && (c ? (cq.size() < CD) : (nq.size() < ND));
            a = m_valid && (wi >= 6);
            if (a) begin
                order.push_back(request_out);
                ocls.push_back(request_critical_out);
            end
            cycle(v, c, d, a);
            if (acc) wi++;
            checks++; if (rdy_obs !== rdy_exp) begin errors++; $display("FAIL prio_ready k=%0d: got %0b expected %0b", k, rdy_obs, rdy_exp); end
            checks++; if (request_valid_out !== m_valid) begin errors++; $display("FAIL prio_valid k=%0d: got %0b expected %0b", k, request_valid_out, m_valid); end
        end
        checks++; if (order.size() != 8) begin errors++; $display("FAIL prio_len: got %0d expected 8", order.size()); end
        for (int i = 0; i < order.size() && i < 8; i++) begin
            checks++; if (order[i] !== exp_order[i]) begin errors++; $display("FAIL prio_item%0d: got %0h expected %0h", i, order[i], exp_order[i]); end
            checks++; if (ocls[i] !== exp_cls[i]) begin errors++; $display("FAIL prio_cls%0d: got %0b expected %0b", i, ocls[i], exp_cls[i]); end
        end
    endtask

    task automatic test_critical_only();
        logic [W-1:0] order[$];
        int first_valid, valid_cycles;
        bit a;
        first_valid  = -1;
        valid_cycles = 0;
        for (int k = 0; k < 16; k++) begin
            a = m_valid;
            if (a) order.push_back(request_out);
            cycle(k < 6, 1'b1, 64'h300 + 64'(k), a);
            if (request_valid_out) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = k + 1;
            end
            if (m_valid) begin
                checks++; if (request_critical_out !== 1'b1) begin errors++; $display("FAIL conly_crit k=%0d: got %0b expected 1", k, request_critical_out); end
            end
        end
        checks++; if (first_valid != 2) begin errors++; $display("FAIL conly_first: got %0d expected 2", first_valid); end
        checks++; if (valid_cycles != 6) begin errors++; $display("FAIL conly_stall: got %0d valid cycles expected 6", valid_cycles); end
        checks++; if (order.size() != 6) begin errors++; $display("FAIL conly_len: got %0d expected 6", order.size()); end
        for (int i = 0; i < order.size() && i < 6; i++) begin
            checks++; if (order[i] !== 64'h300 + 64'(i)) begin errors++; $display("FAIL conly_item%0d: got %0h expected %0h", i, order[i], 64'h300 + 64'(i)); end
        end
    endtask

    task automatic test_full();
        int accepted;
        accepted = 0;
        for (int k = 0; k < 9; k++) begin
            cycle(1'b1, 1'b0, 64'h400 + 64'(k), 1'b0);
            if (rdy_obs) accepted++;
        end
        checks++; if (accepted != 9) begin errors++; $display("FAIL full_accepted: got %0d expected 9", accepted); end
        checks++; if (normal_count_out !== NCW'(8)) begin errors++; $display("FAIL full_ncount: got %0d expected 8", normal_count_out); end
        request_valid_in    = 1'b1;
        request_critical_in = 1'b0;
        request_in          = 64'h409;
        #1;
        checks++; if (request_ready_out !== 1'b0) begin errors++; $display("FAIL full_ready_normal: got %0b expected 0", request_ready_out); end
        request_critical_in = 1'b1;
        request_in          = 64'h4FF;
        #1;
        checks++; if (request_ready_out !== 1'b1) begin errors++; $display("FAIL full_ready_crit: got %0b expected 1", request_ready_out); end
        @(posedge clk_in);
        model_step(1'b1, 1'b1, 64'h4FF, 1'b0);
        @(negedge clk_in);
        request_valid_in = 1'b0;
        checks++; if (critical_count_out !== CCW'(1)) begin errors++; $display("FAIL full_ccount: got %0d expected 1", critical_count_out); end
        checks++; if (normal_count_out !== NCW'(8)) begin errors++; $display("FAIL full_ncount2: got %0d expected 8", normal_count_out); end
        checks++; if (request_out !== 64'h400) begin errors++; $display("FAIL full_slot: got %0h expected 400", request_out); end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] pay[6];
        bit           cls[6];
        pay = '{64'h500, 64'h501, 64'h502, 64'h600, 64'h601, 64'h602};
        cls = '{0, 0, 0, 1, 1, 1};
        for (int k = 0; k < 6; k++) cycle(1'b1, cls[k], pay[k], 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        checks++; if (critical_count_out !== CCW'(3) || normal_count_out !== NCW'(2) || request_valid_out !== 1'b1) begin
            errors++; $display("FAIL arst_setup: got c=%0d n=%0d v=%0b expected c=3 n=2 v=1", critical_count_out, normal_count_out, request_valid_out);
        end
        #2;
        reset_in = 1'b0;
        #1;
        checks++; if (request_valid_out !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0b expected 0", request_valid_out); end
        checks++; if (request_out !== '0) begin errors++; $display("FAIL arst_data: got %0h expected 0", request_out); end
        checks++; if (critical_count_out !== '0 || normal_count_out !== '0) begin
            errors++; $display("FAIL arst_counts: got c=%0d n=%0d expected 0/0", critical_count_out, normal_count_out);
        end
        @(negedge clk_in);
        reset_in = 1'b1;
        model_reset();
        test_normal_order();
    endtask

    task automatic test_random();
        bit v, c, a;
        logic [W-1:0] d;
        for (int k = 0; k < 600; k++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 2) != 0);
            d = {$urandom(), $urandom()};
            a = m_valid ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
            cycle(v, c, d, a);
            checks++; if (rdy_obs !== rdy_exp) begin errors++; $display("FAIL rnd_ready k=%0d: got %0b expected %0b", k, rdy_obs, rdy_exp); end
            checks++; if (request_valid_out !== m_valid) begin errors++; $display("FAIL rnd_valid k=%0d: got %0b expected %0b", k, request_valid_out, m_valid); end
            if (m_valid) begin
                checks++; if (request_out !== m_data) begin errors++; $display("FAIL rnd_data k=%0d: got %0h expected %0h", k, request_out, m_data); end
                checks++; if (request_critical_out !== m_crit) begin errors++; $display("FAIL rnd_crit k=%0d: got %0b expected %0b", k, request_critical_out, m_crit); end
            end
            checks++; if (critical_count_out !== CCW'(cq.size())) begin errors++; $display("FAIL rnd_ccount k=%0d: got %0d expected %0d", k, critical_count_out, cq.size()); end
            checks++; if (normal_count_out !== NCW'(nq.size())) begin errors++; $display("FAIL rnd_ncount k=%0d: got %0d expected %0d", k, normal_count_out, nq.size()); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset_in            = 1'b0;
        request_valid_in    = 1'b0;
        request_critical_in = 1'b0;
        request_in          = '0;
        issue_ack_in        = 1'b0;
        model_reset();
        test_reset();
        test_normal_order();
        apply_reset();
        test_priority();
        apply_reset();
        test_critical_only();
        apply_reset();
        test_full();
        apply_reset();
        test_async_reset();
        apply_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
